// File: rtl/alarm_pkg.sv
// Shared state encodings for the multi-channel latching alarm controller.
package alarm_pkg;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE     = 2'b00;
   localparam logic [STATE_W-1:0] ST_ALARM    = 2'b01;
   localparam logic [STATE_W-1:0] ST_SILENCED = 2'b10;

endpackage

// File: rtl/alarm_ctrl_blink_gen.sv
// Blink timebase: free-running 0..BLINK_PERIOD-1 counter, held at zero while en=0.
// phase is high in the second half of the period; period_done marks the wrap cycle.
module blink_gen #(
   parameter int BLINK_PERIOD = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic phase,
   output logic period_done
);

   localparam int               CNT_W    = $clog2(BLINK_PERIOD - 1) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BLINK_PERIOD / 2);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      cnt_next = '0;
      if (en && (cnt_reg != CNT_LAST)) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign phase       = (cnt_reg >= CNT_HALF);
   assign period_done = en && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/alarm_ctrl.sv
// Multi-channel latching alarm controller: synchronised triggers, blinking lamps, silenceable buzzer.
// Optional buzzer tone modulation is built when ALARM_BUZZ_TONE_EN is defined.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int BLINK_PERIOD = 100_000_000,
   parameter int BUZZ_TIMEOUT = 30,
   parameter int TONE_DIV     = 25_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_CH-1:0]   trig,
   input  logic                ack,
   output logic                alarm_out1,
   output logic                alarm_out2,
   output logic                buzzer_out,
   output logic [NUM_CH-1:0]   active_ch,
   output logic [STATE_W-1:0]  state_o
);

   localparam int                PCNT_W   = $clog2(BUZZ_TIMEOUT) + 1;
   localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(BUZZ_TIMEOUT);

   if ((NUM_CH < 1) || (NUM_CH > 16) || (BLINK_PERIOD < 2) || ((BLINK_PERIOD % 2) != 0)
       || (TONE_DIV < 1)) begin : g_param_err
      $error("alarm_ctrl: illegal parameter value");
   end

   logic [NUM_CH-1:0]  trig_s1_reg;
   logic [NUM_CH-1:0]  trig_s2_reg;
   logic               ack_s1_reg;
   logic               ack_s2_reg;
   logic               ack_s3_reg;
   logic               ack_p;
   logic [NUM_CH-1:0]  active_reg;
   logic [NUM_CH-1:0]  active_next;
   logic               new_set;
   logic [STATE_W-1:0] state_reg;
   logic [STATE_W-1:0] state_next;
   logic [PCNT_W-1:0]  pcnt_reg;
   logic [PCNT_W-1:0]  pcnt_next;
   logic               timeout_hit;
   logic               phase;
   logic               period_done;
   logic               blink_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_s1_reg <= '0;
         trig_s2_reg <= '0;
         ack_s1_reg  <= 1'b0;
         ack_s2_reg  <= 1'b0;
         ack_s3_reg  <= 1'b0;
      end else begin
         trig_s1_reg <= trig;
         trig_s2_reg <= trig_s1_reg;
         ack_s1_reg  <= ack;
         ack_s2_reg  <= ack_s1_reg;
         ack_s3_reg  <= ack_s2_reg;
      end
   end

   assign ack_p = ack_s2_reg & ~ack_s3_reg;

   // A live trigger always wins over an acknowledge clearing the same channel.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign active_next[gi] = trig_s2_reg[gi] | (active_reg[gi] & ~ack_p);
   end

   assign new_set     = |(trig_s2_reg & ~active_reg);
   assign timeout_hit = (BUZZ_TIMEOUT != 0) && (pcnt_reg == PCNT_MAX);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (|active_reg) state_next = ST_ALARM;
         end
         ST_ALARM: begin
            if (ack_p && !(|active_next)) begin
               state_next = ST_IDLE;
            end else if (ack_p || timeout_hit) begin
               state_next = ST_SILENCED;
            end
         end
         ST_SILENCED: begin
            if (new_set) begin
               state_next = ST_ALARM;
            end else if (ack_p && !(|active_next)) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Timeout restarts on every (re-)entry to ALARM and only advances while in ALARM.
   always_comb begin
      pcnt_next = pcnt_reg;
      if ((state_next == ST_ALARM) && (state_reg != ST_ALARM)) begin
         pcnt_next = '0;
      end else if ((state_reg == ST_ALARM) && period_done && (pcnt_reg != PCNT_MAX)) begin
         pcnt_next = pcnt_reg + PCNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_reg <= '0;
         state_reg  <= ST_IDLE;
         pcnt_reg   <= '0;
      end else begin
         active_reg <= active_next;
         state_reg  <= state_next;
         pcnt_reg   <= pcnt_next;
      end
   end

   assign blink_en = (state_reg != ST_IDLE);

   blink_gen #(
      .BLINK_PERIOD (BLINK_PERIOD)
   ) u_blink (
      .clk         (clk),
      .rst         (rst),
      .en          (blink_en),
      .phase       (phase),
      .period_done (period_done)
   );

   assign alarm_out1 = blink_en & phase;
   assign alarm_out2 = ~alarm_out1;
   assign active_ch  = active_reg;
   assign state_o    = state_reg;

`ifdef ALARM_BUZZ_TONE_EN
   localparam int               TONE_W    = $clog2(TONE_DIV - 1) + 1;
   localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);

   logic [TONE_W-1:0] tone_cnt_reg;
   logic              tone_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tone_cnt_reg <= '0;
         tone_reg     <= 1'b0;
      end else if (state_reg != ST_ALARM) begin
         tone_cnt_reg <= '0;
         tone_reg     <= 1'b0;
      end else if (tone_cnt_reg == TONE_LAST) begin
         tone_cnt_reg <= '0;
         tone_reg     <= ~tone_reg;
      end else begin
         tone_cnt_reg <= tone_cnt_reg + TONE_W'(1);
      end
   end

   assign buzzer_out = (state_reg == ST_ALARM) & phase & tone_reg;
`else
   assign buzzer_out = (state_reg == ST_ALARM) & phase;
`endif

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Multi-channel latching alarm controller; parametrised successor of the single-input blinking alarm.
- Synchronises NUM_CH trigger inputs and latches active channels until acknowledged.
- Drives complementary blinking lamp outputs and a buzzer that can be silenced by acknowledge or by timeout.
- Sits between the sensor/comparison logic and board LEDs/buzzer pins.

Parameters:
- NUM_CH, 4, number of trigger channels (1..16).
- BLINK_PERIOD, 100_000_000, blink period in clk cycles (even, >=2); lamp is high for the second half of each period.
- BUZZ_TIMEOUT, 30, completed blink periods in ALARM before auto-silence; 0 disables the timeout.
- TONE_DIV, 25_000, half-period in clk cycles of the buzzer tone; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- trig  in  NUM_CH  asynchronous per-channel alarm requests, level-sensitive.
- ack  in  1  asynchronous acknowledge push-button, active-high.
- alarm_out1  out  1  blinking lamp, active in the second half of each period.
- alarm_out2  out  1  always the inverse of alarm_out1.
- buzzer_out  out  1  buzzer drive.
- active_ch  out  NUM_CH  latched channel flags.
- state_o  out  2  current state: 00 IDLE, 01 ALARM, 10 SILENCED.

Behaviour:
- Reset (async, any time including mid-alarm): state IDLE, alarm_out1=0, alarm_out2=1, buzzer_out=0, active_ch=0, all counters and synchronisers 0.
- trig and ack each pass through a 2-flop synchroniser. The ack rising edge yields a one-cycle internal pulse, ack_p.
- Latching: active_ch[i] is set on any cycle with synced trig[i]=1. On ack_p it clears only if synced trig[i]=0. If set and clear coincide, set wins.
- Latency: trig[i] first sampled high at edge k -> active_ch[i]=1 after edge k+2 -> state_o=ALARM after edge k+3.
- Blink counter: counts 0..BLINK_PERIOD-1 and wraps to 0.
  - Held at 0 in IDLE.
  - Runs in ALARM and SILENCED.
  - Emits period_done when it wraps.
  - phase = (cnt >= BLINK_PERIOD/2).
- Period counter: counts period_done pulses in ALARM. Cleared on entry to ALARM. Saturates at BUZZ_TIMEOUT.
- IDLE: alarm_out1=0, buzzer_out=0. Go to ALARM when active_ch != 0.
- ALARM:
  - alarm_out1=phase, buzzer_out=phase.
  - Go to SILENCED on ack_p.
  - Go to SILENCED when the period counter reaches BUZZ_TIMEOUT (BUZZ_TIMEOUT != 0).
  - Go to IDLE if ack_p clears every active_ch bit in the same cycle; IDLE takes priority over SILENCED.
- SILENCED:
  - alarm_out1=phase, buzzer_out=0.
  - A channel newly set (0->1) returns the block to ALARM. The period counter is cleared; the blink counter is not reset.
  - ack_p that leaves active_ch=0 -> IDLE.
  - If ack_p and a new set occur together, ALARM wins.
- Leaving to IDLE zeroes the blink counter on the next edge.
- A trigger held high keeps its channel latched: ack silences but cannot clear it.
- Counter widths are $clog2 of their maximum value plus 1. There is no overflow, because each counter wraps or saturates before reaching its width limit.

Optional Feature:
- Macro: ALARM_BUZZ_TONE_EN.
- Defined: buzzer_out = phase AND tone, where tone toggles every TONE_DIV cycles. The tone counter is reset in IDLE/SILENCED and runs only in ALARM.
- Undefined: buzzer_out = phase in ALARM (steady on for half the period). TONE_DIV is ignored and no tone logic is built.

Decomposition:
- Package alarm_pkg holds:
  - state encodings ST_IDLE=2'b00, ST_ALARM=2'b01, ST_SILENCED=2'b10;
  - the 2-bit state width constant.
- Sub-module blink_gen(clk, rst, en, phase, period_done):
  - parametrised by BLINK_PERIOD;
  - holds its counter at 0 while en=0.

Test Plan (NUM_CH=4, BLINK_PERIOD=10, BUZZ_TIMEOUT=3, TONE_DIV=2):
- Reset check: assert rst mid-ALARM -> same cycle state_o=00, alarm_out1=0, alarm_out2=1, buzzer_out=0, active_ch=0.
- Trigger latency: pulse trig=4'b0100 for 1 cycle -> active_ch=4'b0100 two edges later, state_o=01 one edge after that. alarm_out1 low 5 cycles then high 5 cycles, repeating. buzzer_out equals alarm_out1 and alarm_out2 is its inverse.
- Ack with held trigger: hold trig[0]=1, pulse ack -> state_o=10, buzzer_out=0, lamp still blinking, active_ch[0]=1. Drop trig[0], pulse ack -> state_o=00, active_ch=0, alarm_out1=0.
- Timeout: trig[1] pulse with no ack -> after 3 full blink periods (30 cycles of running) state_o=10, buzzer_out=0.
- Re-arm: in SILENCED with active_ch=4'b0001, raise trig[3] -> state_o=01 and the timeout restarts. If ack_p lands on the same edge as the trig[3] set, state_o=01 and active_ch[3]=1.
- Tone (ALARM_BUZZ_TONE_EN defined): in ALARM during phase=1, buzzer_out toggles every 2 cycles; during phase=0, buzzer_out=0.
